// File: rtl/billiard_pkg.sv
// billiard_pkg: shared fixed-point formats, board limits and ball states for the billiard table.
package billiard_pkg;
   localparam int FRAC      = 6;
   localparam int POS_W     = 18;
   localparam int VEL_W     = 12;
   localparam int INIT_X    = 160;
   localparam int INIT_Y    = 240;
   localparam int BALL_SIZE = 16;
   localparam int X_MIN     = 32;
   localparam int X_MAX     = 608;
   localparam int Y_MIN     = 32;
   localparam int Y_MAX     = 448;
   localparam int FRICTION  = 1;
   localparam int MAX_SPEED = 1024;
   typedef enum logic [1:0] {IDLE, MOVING, SUNK} ball_state_t;
   typedef logic signed [POS_W-1:0] pos_t;
   typedef logic signed [VEL_W-1:0] vel_t;
   function automatic pos_t to_pos(input int px);
      return pos_t'(px <<< FRAC);
   endfunction
endpackage

// File: rtl/ball_motion_ctrl_friction_step.sv
// friction_step: per-axis velocity helpers, friction decay toward zero and shot speed clamp.
//   vin      : velocity after bounces     vout     : vin moved FRICTION toward 0, never crossing 0
//   shot_in  : raw shot velocity          shot_out : shot_in clamped to +/-MAX_SPEED
module friction_step
   import billiard_pkg::*;
(
   input  vel_t vin,
   input  vel_t shot_in,
   output vel_t vout,
   output vel_t shot_out
);
   localparam vel_t F    = vel_t'(FRICTION);
   localparam vel_t VMAX = vel_t'(MAX_SPEED);
   always_comb begin
      vout     = vin > F ? vin - F : vin < -F ? vin + F : '0;
      shot_out = shot_in > VMAX ? VMAX : shot_in < -VMAX ? -VMAX : shot_in;
   end
endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-ball motion engine, applies shots, bounces, friction and hole capture once per frame.
//   clk, resetN (async, active-low)     startOfFrame : one-cycle frame pulse
//   shotValid, shotVx, shotVy           : shot request with signed fixed-point velocity
//   collBorderX/Y, collHole, respawn    : event pulses
//   topLeftX/Y : integer pixel position  moving/sunk/shotReady : state flags
module ball_motion_ctrl
   import billiard_pkg::*;
(
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               shotValid,
   input  logic signed [11:0] shotVx,
   input  logic signed [11:0] shotVy,
   input  logic               collBorderX,
   input  logic               collBorderY,
   input  logic               collHole,
   input  logic               respawn,
   output logic [10:0]        topLeftX,
   output logic [10:0]        topLeftY,
   output logic               moving,
   output logic               sunk,
   output logic               shotReady
);
   localparam pos_t X0  = to_pos(INIT_X);
   localparam pos_t Y0  = to_pos(INIT_Y);
   localparam pos_t XLO = to_pos(X_MIN);
   localparam pos_t XHI = to_pos(X_MAX - BALL_SIZE);
   localparam pos_t YLO = to_pos(Y_MIN);
   localparam pos_t YHI = to_pos(Y_MAX - BALL_SIZE);

   ball_state_t state, state_nx;
   pos_t px, py, px_add, py_add, px_clamp, py_clamp;
   vel_t vx, vy, vx_ref, vy_ref, vx_bnc, vy_bnc, vx_fric, vy_fric, shot_vx_c, shot_vy_c;
   logic lx, ly, lh, shot_go, frame_go;

   // A latched border hit already flipped the axis, so a wall clamp must not flip it back.
   always_comb begin
      shot_go  = state == IDLE && shotValid && (shotVx != '0 || shotVy != '0);
      frame_go = state == MOVING && startOfFrame;
      vx_ref   = lx ? -vx : vx;
      vy_ref   = ly ? -vy : vy;
      px_add   = px + pos_t'(vx_ref);
      py_add   = py + pos_t'(vy_ref);
      px_clamp = px_add < XLO ? XLO : px_add > XHI ? XHI : px_add;
      py_clamp = py_add < YLO ? YLO : py_add > YHI ? YHI : py_add;
      vx_bnc   = (px_clamp != px_add && !lx) ? -vx_ref : vx_ref;
      vy_bnc   = (py_clamp != py_add && !ly) ? -vy_ref : vy_ref;
   end

   friction_step u_fric_x (.vin(vx_bnc), .shot_in(shotVx), .vout(vx_fric), .shot_out(shot_vx_c));
   friction_step u_fric_y (.vin(vy_bnc), .shot_in(shotVy), .vout(vy_fric), .shot_out(shot_vy_c));

   always_ff @(posedge clk or negedge resetN)
      if (!resetN) state <= IDLE;
      else state <= state_nx;

   always_comb
      state_nx = respawn ? IDLE :
                 shot_go ? MOVING :
                 frame_go ? (lh ? SUNK : (vx_fric == '0 && vy_fric == '0) ? IDLE : MOVING) :
                 state;

   // Pulses coinciding with startOfFrame belong to the next frame, so the latch reloads from them.
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         px <= X0;
         py <= Y0;
         vx <= '0;
         vy <= '0;
         {lx, ly, lh} <= '0;
      end else if (respawn) begin
         px <= X0;
         py <= Y0;
         vx <= '0;
         vy <= '0;
         {lx, ly, lh} <= '0;
      end else begin
         {lx, ly, lh} <= startOfFrame ? {collBorderX, collBorderY, collHole} :
                                        {lx | collBorderX, ly | collBorderY, lh | collHole};
         if (shot_go) begin
            vx <= shot_vx_c;
            vy <= shot_vy_c;
         end else if (frame_go && lh) begin
            vx <= '0;
            vy <= '0;
         end else if (frame_go) begin
            px <= px_clamp;
            py <= py_clamp;
            vx <= vx_fric;
            vy <= vy_fric;
         end
      end

   always_comb begin
      topLeftX  = px[FRAC +: 11];
      topLeftY  = py[FRAC +: 11];
      moving    = state == MOVING;
      sunk      = state == SUNK;
      shotReady = state == IDLE;
   end
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: scenario and randomized checks of ball_motion_ctrl against an integer reference model.
module tb_ball_motion_ctrl;
   logic clk = 0, resetN = 0, startOfFrame = 0, shotValid = 0;
   logic collBorderX = 0, collBorderY = 0, collHole = 0, respawn = 0;
   logic signed [11:0] shotVx = 0, shotVy = 0;
   logic [10:0] topLeftX, topLeftY;
   logic moving, sunk, shotReady;
   logic [24:0] got;
   int vectors = 0, miscompares = 0;

   ball_motion_ctrl dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .shotValid(shotValid),
      .shotVx(shotVx), .shotVy(shotVy), .collBorderX(collBorderX), .collBorderY(collBorderY),
      .collHole(collHole), .respawn(respawn), .topLeftX(topLeftX), .topLeftY(topLeftY),
      .moving(moving), .sunk(sunk), .shotReady(shotReady)
   );

   always #5 clk = ~clk;
   assign got = {topLeftX, topLeftY, moving, sunk, shotReady};

   // Reference model: positions/velocities in 1/64 pixel units, state 0=idle 1=moving 2=sunk.
   int ms, mpx, mpy, mvx, mvy;
   bit mlx, mly, mlh;
   localparam int XLO = 32 * 64, XHI = 592 * 64, YLO = 32 * 64, YHI = 432 * 64;

   function automatic void model_reset();
      ms = 0; mpx = 160 * 64; mpy = 240 * 64; mvx = 0; mvy = 0;
      mlx = 0; mly = 0; mlh = 0;
   endfunction

   function automatic int clampv(input int v);
      return v > 1024 ? 1024 : v < -1024 ? -1024 : v;
   endfunction

   function automatic void move_axis(inout int p, inout int v, input bit flip, input int lo, input int hi);
      if (flip) v = -v;
      p = p + v;
      if (p < lo || p > hi) begin
         p = p < lo ? lo : hi;
         if (!flip) v = -v;
      end
      if (v > 0) v = v > 1 ? v - 1 : 0;
      else if (v < 0) v = v < -1 ? v + 1 : 0;
   endfunction

   function automatic logic [24:0] expv();
      return {11'(mpx / 64), 11'(mpy / 64), ms == 1, ms == 2, ms == 0};
   endfunction

   function automatic void model_update();
      if (!resetN || respawn) begin
         model_reset();
         return;
      end
      if (ms == 1 && startOfFrame) begin
         if (mlh) begin
            mvx = 0; mvy = 0; ms = 2;
         end else begin
            move_axis(mpx, mvx, mlx, XLO, XHI);
            move_axis(mpy, mvy, mly, YLO, YHI);
            if (mvx == 0 && mvy == 0) ms = 0;
         end
      end else if (ms == 0 && shotValid && (shotVx != 0 || shotVy != 0)) begin
         mvx = clampv(int'(shotVx)); mvy = clampv(int'(shotVy)); ms = 1;
      end
      if (startOfFrame) {mlx, mly, mlh} = {collBorderX, collBorderY, collHole};
      else {mlx, mly, mlh} = {mlx | collBorderX, mly | collBorderY, mlh | collHole};
   endfunction

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      {startOfFrame, shotValid, collBorderX, collBorderY, collHole, respawn} = '0;
   endtask

   task automatic frame();
      step();
      startOfFrame = 1;
      step();
   endtask

   task automatic test_reset();
      shotVx = 200; shotVy = -100; shotValid = 1;
      step();
      frame();
      frame();
      vectors++;
      if (got !== expv()) begin miscompares++; $display("FAIL pre_reset got=%h exp=%h", got, expv()); end
      #2 resetN = 0;
      #1 model_reset();
      vectors++;
      if (got !== {11'd160, 11'd240, 3'b001}) begin miscompares++; $display("FAIL async_reset got=%h exp=%h", got, {11'd160, 11'd240, 3'b001}); end
      step();
      vectors++;
      if (got !== {11'd160, 11'd240, 3'b001}) begin miscompares++; $display("FAIL held_reset got=%h exp=%h", got, {11'd160, 11'd240, 3'b001}); end
      resetN = 1;
      step();
   endtask

   task automatic test_shot_friction();
      shotVx = 128; shotVy = 0; shotValid = 1;
      step();
      vectors++;
      if (got !== {11'd160, 11'd240, 3'b100}) begin miscompares++; $display("FAIL shot_load got=%h exp=%h", got, {11'd160, 11'd240, 3'b100}); end
      frame();
      vectors++;
      if (got !== {11'd162, 11'd240, 3'b100}) begin miscompares++; $display("FAIL first_frame got=%h exp=%h", got, {11'd162, 11'd240, 3'b100}); end
      for (int i = 1; i < 128; i++) begin
         frame();
         vectors++;
         if (got !== expv()) begin miscompares++; $display("FAIL friction_frame%0d got=%h exp=%h", i, got, expv()); end
      end
      vectors++;
      if (got !== {11'd289, 11'd240, 3'b001}) begin miscompares++; $display("FAIL friction_stop got=%h exp=%h", got, {11'd289, 11'd240, 3'b001}); end
   endtask

   task automatic test_border_bounce();
      respawn = 1;
      step();
      shotVx = 128; shotVy = 0; shotValid = 1;
      step();
      collBorderX = 1;
      step();
      frame();
      vectors++;
      if (got !== {11'd158, 11'd240, 3'b100}) begin miscompares++; $display("FAIL border_x got=%h exp=%h", got, {11'd158, 11'd240, 3'b100}); end
      frame();
      vectors++;
      if (got !== {11'd156, 11'd240, 3'b100} || got !== expv()) begin miscompares++; $display("FAIL border_x_next got=%h exp=%h", got, {11'd156, 11'd240, 3'b100}); end
   endtask

   task automatic test_hole();
      respawn = 1;
      step();
      shotVx = 0; shotVy = 0; shotValid = 1;
      step();
      vectors++;
      if (got !== {11'd160, 11'd240, 3'b001}) begin miscompares++; $display("FAIL zero_shot got=%h exp=%h", got, {11'd160, 11'd240, 3'b001}); end
      shotVx = 100; shotVy = 50; shotValid = 1;
      step();
      frame();
      collHole = 1;
      step();
      frame();
      vectors++;
      if (got !== {11'd161, 11'd240, 3'b010}) begin miscompares++; $display("FAIL sunk got=%h exp=%h", got, {11'd161, 11'd240, 3'b010}); end
      shotVx = 300; shotValid = 1;
      step();
      frame();
      frame();
      vectors++;
      if (got !== {11'd161, 11'd240, 3'b010} || got !== expv()) begin miscompares++; $display("FAIL sunk_frozen got=%h exp=%h", got, {11'd161, 11'd240, 3'b010}); end
      respawn = 1;
      step();
      vectors++;
      if (got !== {11'd160, 11'd240, 3'b001}) begin miscompares++; $display("FAIL respawn got=%h exp=%h", got, {11'd160, 11'd240, 3'b001}); end
   endtask

   task automatic test_clamp();
      bit seen = 0;
      int maxx = 0;
      shotVx = 2000; shotVy = -2000; shotValid = 1;
      step();
      frame();
      vectors++;
      if (got !== {11'd176, 11'd224, 3'b100}) begin miscompares++; $display("FAIL speed_clamp got=%h exp=%h", got, {11'd176, 11'd224, 3'b100}); end
      for (int i = 0; i < 40; i++) begin
         frame();
         if (topLeftX == 592) seen = 1;
         if (int'(topLeftX) > maxx) maxx = int'(topLeftX);
         vectors++;
         if (got !== expv()) begin miscompares++; $display("FAIL clamp_frame%0d got=%h exp=%h", i, got, expv()); end
      end
      vectors++;
      if (!seen || maxx != 592) begin miscompares++; $display("FAIL right_wall reached=%0d max_x=%0d exp_max=592", seen, maxx); end
   endtask

   task automatic test_simultaneous();
      respawn = 1;
      step();
      shotVx = 0; shotVy = 128; shotValid = 1;
      step();
      step();
      collBorderY = 1; startOfFrame = 1;
      step();
      vectors++;
      if (got !== {11'd160, 11'd242, 3'b100}) begin miscompares++; $display("FAIL coincident_border got=%h exp=%h", got, {11'd160, 11'd242, 3'b100}); end
      frame();
      vectors++;
      if (got !== {11'd160, 11'd240, 3'b100} || got !== expv()) begin miscompares++; $display("FAIL deferred_border got=%h exp=%h", got, {11'd160, 11'd240, 3'b100}); end
      step();
      respawn = 1; startOfFrame = 1; shotValid = 1; shotVx = 50;
      step();
      vectors++;
      if (got !== {11'd160, 11'd240, 3'b001}) begin miscompares++; $display("FAIL respawn_priority got=%h exp=%h", got, {11'd160, 11'd240, 3'b001}); end
   endtask

   task automatic test_random();
      bit last_sof = 0;
      int r;
      for (int i = 0; i < 3000; i++) begin
         startOfFrame = !last_sof && ($urandom % 3 == 0);
         shotValid = $urandom % 6 == 0;
         r = $urandom_range(0, 400) - 200;
         shotVx = ($urandom % 5 == 0) ? 12'($urandom) : ($urandom % 5 == 0) ? 12'sd0 : 12'(r);
         r = $urandom_range(0, 400) - 200;
         shotVy = ($urandom % 5 == 0) ? 12'($urandom) : ($urandom % 5 == 0) ? 12'sd0 : 12'(r);
         collBorderX = $urandom % 16 == 0;
         collBorderY = $urandom % 16 == 0;
         collHole = $urandom % 80 == 0;
         respawn = $urandom % 150 == 0;
         last_sof = startOfFrame;
         step();
         vectors++;
         if (got !== expv()) begin miscompares++; $display("FAIL random_cycle%0d got=%h exp=%h", i, got, expv()); end
      end
   endtask

   initial begin
      model_reset();
      step();
      step();
      resetN = 1;
      step();
      test_reset();
      test_shot_friction();
      test_border_bounce();
      test_hole();
      test_clamp();
      test_simultaneous();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
Per-ball motion engine for the billiard table. Sits directly upstream of the ball bitmap/draw-request stage that feeds the objects mux, and drives the ball's on-screen top-left position. Once per video frame it applies a shot, border bounces, friction and hole capture. Collision pulses come from the collision detector, which watches the same draw requests the mux consumes.

Parameters:
FRAC, 6, fractional bits of the fixed-point position and velocity
INIT_X, 160, respawn/reset top-left X in pixels
INIT_Y, 240, respawn/reset top-left Y in pixels
BALL_SIZE, 16, ball bitmap edge in pixels
X_MIN, 32, lowest legal top-left X
X_MAX, 608, right board edge; top-left X never exceeds X_MAX-BALL_SIZE
Y_MIN, 32, lowest legal top-left Y
Y_MAX, 448, bottom board edge; top-left Y never exceeds Y_MAX-BALL_SIZE
FRICTION, 1, per-frame magnitude decrement per axis (fixed-point LSBs)
MAX_SPEED, 1024, velocity magnitude clamp per axis (fixed-point; 16 px/frame)

Ports:
clk  in  1  system clock
resetN  in  1  reset
startOfFrame  in  1  one-cycle pulse per video frame
shotValid  in  1  one-cycle shot request
shotVx  in  12  signed X velocity of the shot, fixed-point
shotVy  in  12  signed Y velocity of the shot, fixed-point
collBorderX  in  1  pulse: ball touched a left or right border
collBorderY  in  1  pulse: ball touched a top or bottom border
collHole  in  1  pulse: ball overlapped a hole
respawn  in  1  pulse: return the ball to its initial position
topLeftX  out  11  ball top-left X, integer pixels
topLeftY  out  11  ball top-left Y, integer pixels
moving  out  1  state is MOVING
sunk  out  1  state is SUNK
shotReady  out  1  state is IDLE

Behaviour:
- Reset: resetN, asynchronous, active-low; clock clk.
- Reset values: state IDLE; position (INIT_X,INIT_Y)<<FRAC; velocity 0; latches cleared; topLeftX=INIT_X; topLeftY=INIT_Y; moving=0; sunk=0; shotReady=1.
- Position registers: signed 18 bit (11 integer + FRAC). Velocity registers: signed 12 bit. topLeftX/topLeftY are the position shifted right by FRAC, taken from registers.
- Collision latches (border X, border Y, hole): sticky, set by their pulses.
  - Consumed and cleared on startOfFrame.
  - A pulse arriving in the same cycle as startOfFrame sets the latch for the following frame.
- States:
  - IDLE:
    - shotValid with (shotVx,shotVy) not both 0: load velocity, each axis clamped to ±MAX_SPEED; next state MOVING.
    - Zero shot: ignored, stays IDLE.
  - MOVING, on startOfFrame, in this order:
    - Hole latch set: velocity becomes 0; next state SUNK; position frozen.
    - Otherwise, border-X latch set: vx becomes -vx. Border-Y latch set: vy becomes -vy. At most one negation per axis per frame.
    - Position += velocity.
    - Clamp each axis to [MIN, MAX-BALL_SIZE]. If clamped, negate that axis velocity, unless it was already negated this frame.
    - Friction: each velocity axis moves FRICTION toward 0, saturating at 0 with no sign crossing.
    - Both axes 0 after friction: next state IDLE.
    - shotValid is ignored in MOVING.
  - SUNK: position and velocity held; shotValid ignored.
- respawn, from any state: position=INIT, velocity=0, latches cleared, next state IDLE.
- respawn has priority over startOfFrame and shotValid in the same cycle.
- Latency: topLeftX/Y reflect a frame update 1 clk after the startOfFrame pulse. State outputs (moving, sunk, shotReady) change 1 clk after the triggering event.
- Velocity arithmetic is sign-extended to 18 bits before adding. The negation of -2048 is prevented by the clamp.
- startOfFrame is not asserted in consecutive cycles; back-to-back pulses still apply two independent updates.

Decomposition:
- billiard_pkg:
  - FRAC, POS_W=18, VEL_W=12 and the board limit constants.
  - typedef enum {IDLE, MOVING, SUNK} ball_state_t.
  - Signed pos_t and vel_t typedefs.
- Sub-module friction_step: combinational saturating decrement of magnitude toward zero, plus the ±MAX_SPEED clamp. Instantiated once per axis.

Test Plan:
- Reset mid-MOVING → next cycle topLeftX=160, topLeftY=240, shotReady=1, moving=0, sunk=0.
- Shot vx=128, vy=0, then startOfFrame → topLeftX=162 one clk later, internal vx=127. After 128 frames vx=0, moving=0, shotReady=1.
- Moving with vx=+128: collBorderX pulse mid-frame → at next startOfFrame vx=-128 before the add; topLeftX decreases by 2; vx=-127 after friction.
- collHole pulse while MOVING → after next startOfFrame sunk=1 and topLeft frozen. shotValid then ignored. respawn → topLeft=(160,240), shotReady=1.
- shotVx=2000, shotVy=-2000 → velocity clamped to +1024/-1024. Ball reaches X_MAX-16=592, clamps to 592, vx negated.
- Simultaneous events:
  - collBorderY in the same cycle as startOfFrame → vy unchanged this frame, negated next frame.
  - respawn together with startOfFrame → position=INIT, IDLE.
